// File: rtl/logic_pkg.sv
// ============================================================================
// Module : logic_pkg
// Brief  : Shared op codes and FSM state encodings for the serial logic unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/logic_slice.sv
// ============================================================================
// Module : logic_slice
// Brief  : Combinational SLICE-bit, eight-operation gate slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module logic_slice
    import logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a_slice,
    input  logic [SLICE-1:0] b_slice,
    output logic [SLICE-1:0] y_slice
);

    always_comb begin
        y_slice = a_slice;
        case (op)
            OP_NOT:  y_slice = ~a_slice;
            OP_AND:  y_slice = a_slice & b_slice;
            OP_OR:   y_slice = a_slice | b_slice;
            OP_XOR:  y_slice = a_slice ^ b_slice;
            OP_NAND: y_slice = ~(a_slice & b_slice);
            OP_NOR:  y_slice = ~(a_slice | b_slice);
            OP_XNOR: y_slice = ~(a_slice ^ b_slice);
            OP_PASS: y_slice = a_slice;
            default: y_slice = a_slice;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bitwise_logic_serial.sv
// ============================================================================
// Module : bitwise_logic_serial
// Brief  : WIDTH-bit logic unit evaluating SLICE bits per cycle, start/busy/done.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bitwise_logic_serial
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_nslice = WIDTH / SLICE;
    localparam int c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_nslice - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_width_check
            $error("bitwise_logic_serial: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_t             r_state;
    logic [c_cnt_w-1:0] r_idx;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_y_slice;

    assign w_a_slice = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_b_slice = r_b[int'(r_idx) * SLICE +: SLICE];

    // One shared gate slice walks across the latched word
    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op      (r_op),
        .a_slice (w_a_slice),
        .b_slice (w_b_slice),
        .y_slice (w_y_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_op     <= OP_NOT;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result[int'(r_idx) * SLICE +: SLICE] <= w_y_slice;
                    // Counter parks on the last slice rather than wrapping
                    if (r_idx == c_last_idx) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + c_cnt_w'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

`default_nettype wire
